// File: rtl/enc_pkg.sv
// Shared types and constants for the LFSR encryption engine.
package enc_pkg;

  // Controller states: parameter fetch, then an RD/WR pair per output byte.
  typedef enum logic [2:0] {
    S_IDLE,
    S_P61,
    S_P62,
    S_P63,
    S_PCAP,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  // Fixed locations of the run parameters in data memory.
  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] TAP_ADDR  = 8'd62;
  localparam logic [7:0] INIT_ADDR = 8'd63;

  // Character used for leading/trailing padding.
  localparam logic [7:0] PAD_CHAR = 8'h20;

  // Legal range of the leading pad length.
  localparam logic [7:0] PRE_MIN = 8'd10;
  localparam logic [7:0] PRE_MAX = 8'd15;

  // Force a raw pad-length byte into [PRE_MIN, PRE_MAX].
  function automatic logic [7:0] clamp_pre(input logic [7:0] raw);
    logic [7:0] v;
    v = raw;
    if (raw < PRE_MIN) v = PRE_MIN;
    if (raw > PRE_MAX) v = PRE_MAX;
    return v;
  endfunction

  // XOR the low seven bits with the key and put even parity into bit 7.
  function automatic logic [7:0] seal_byte(input logic [7:0] plain, input logic [6:0] key);
    logic [6:0] c7;
    c7 = plain[6:0] ^ key;
    return {^c7, c7};
  endfunction

endpackage

// File: rtl/lfsr7_step.sv
// One step of the 7-bit Fibonacci-style LFSR: shift left, feed back tap parity.
module lfsr7_step (
  input  logic [6:0] state_i,
  input  logic [6:0] taps_i,
  output logic [6:0] next_o
);

  // New bit 0 is the XOR of all tapped state bits.
  always_comb begin
    next_o = {state_i[5:0], ^(state_i & taps_i)};
  end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Reads a message and run parameters from data memory, pads the message,
// encrypts it with a 7-bit LFSR keystream and writes the result back.
module lfsr_encrypt_engine
  import enc_pkg::*;
#(
  parameter int MSG_MAX  = 49,
  parameter int OUT_BASE = 64,
  parameter int OUT_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       mem_wr_en_q, mem_wr_en_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] taps_q, taps_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] idx_q, idx_d;

  logic [6:0] lfsr_next;
  logic [7:0] plain;

  // True when output byte idx carries a message character rather than padding.
  function automatic logic in_msg(input logic [7:0] idx, input logic [7:0] pre);
    logic [8:0] lo;
    logic [8:0] hi;
    lo = {1'b0, pre};
    hi = {1'b0, pre} + 9'(MSG_MAX);
    return ({1'b0, idx} >= lo) && ({1'b0, idx} < hi);
  endfunction

  lfsr7_step u_step (
    .state_i(lfsr_q),
    .taps_i (taps_q),
    .next_o (lfsr_next)
  );

  // Plain byte for the current WR cycle: read data is the character fetched in RD.
  always_comb begin
    plain = in_msg(idx_q, pre_q) ? mem_rdata : PAD_CHAR;
  end

  // Write data is only meaningful while the strobe is up; otherwise zero.
  always_comb begin
    mem_wdata = 8'h00;
    if (state_q == S_WR) mem_wdata = seal_byte(plain, lfsr_q);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    taps_d      = taps_q;
    pre_d       = pre_q;
    idx_d       = idx_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = 8'h00;
    mem_wr_en_d = 1'b0;

    case (state_q)
      S_IDLE:  if (start) state_d = S_P61;
      S_P61:   state_d = S_P62;
      S_P62: begin
        pre_d   = clamp_pre(mem_rdata);
        state_d = S_P63;
      end
      S_P63: begin
        taps_d  = mem_rdata[6:0];
        state_d = S_PCAP;
      end
      S_PCAP: begin
        lfsr_d  = (mem_rdata[6:0] == 7'h00) ? 7'h01 : mem_rdata[6:0];
        idx_d   = 8'h00;
        state_d = S_RD;
      end
      S_RD:    state_d = S_WR;
      S_WR: begin
        lfsr_d = lfsr_next;
        if (idx_q == 8'(OUT_LEN - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD;
        end
      end
      S_DONE:  if (start) state_d = S_P61;
      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of the state being entered, so they are
    // stable for the whole cycle spent in that state.
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    case (state_d)
      S_P61:  mem_addr_d = PRE_ADDR;
      S_P62:  mem_addr_d = TAP_ADDR;
      S_P63:  mem_addr_d = INIT_ADDR;
      S_RD:   mem_addr_d = in_msg(idx_d, pre_d) ? (idx_d - pre_d) : 8'h00;
      S_WR: begin
        mem_addr_d  = 8'(OUT_BASE) + idx_d;
        mem_wr_en_d = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wr_en_q <= 1'b0;
      lfsr_q      <= 7'h00;
      taps_q      <= 7'h00;
      pre_q       <= 8'h00;
      idx_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_en_q <= mem_wr_en_d;
      lfsr_q      <= lfsr_d;
      taps_q      <= taps_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr_en = mem_wr_en_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Bench for lfsr_encrypt_engine: data memory model, reference encryptor,
// directed scenarios plus randomized images.
module tb_lfsr_encrypt_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  always #5 clk = ~clk;

  lfsr_encrypt_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory: registered read, DUT writes win over bench preload writes.
  logic [7:0] dm [256];
  logic       tb_we;
  logic [7:0] tb_waddr;
  logic [7:0] tb_wdata;

  always @(posedge clk) begin
    mem_rdata <= dm[mem_addr];
    if (mem_wr_en) dm[mem_addr] <= mem_wdata;
    else if (tb_we) dm[tb_waddr] <= tb_wdata;
  end

  logic [7:0] img    [128];
  logic [7:0] ref_out[64];
  logic [7:0] save_a [64];
  logic [7:0] save_b [64];

  int total = 0;
  int bad   = 0;

  int r_first, r_last, r_done, r_nwr, r_addr_ok, r_busy1, r_busy_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic build_image(input string msg, input logic [7:0] pre, input logic [7:0] taps,
                             input logic [7:0] init, input logic [7:0] fill);
    for (int a = 0; a < 128; a++) img[a] = 8'h00;
    for (int k = 0; k < msg.len() && k < 49; k++) img[k] = msg[k];
    img[61] = pre;
    img[62] = taps;
    img[63] = init;
    for (int a = 64; a < 128; a++) img[a] = fill;
  endtask

  task automatic load_image();
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      tb_we    = 1'b1;
      tb_waddr = 8'(a);
      tb_wdata = img[a];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Reference: build the padded plaintext and run the keystream with plain arithmetic.
  task automatic compute_ref();
    int pre;
    int taps;
    int l;
    int p;
    int c7;
    pre  = img[61];
    if (pre < 10) pre = 10;
    if (pre > 15) pre = 15;
    taps = img[62] & 8'h7f;
    l    = img[63] & 8'h7f;
    if (l == 0) l = 1;
    for (int i = 0; i < 64; i++) begin
      p  = (i >= pre && i < pre + 49) ? int'(img[i - pre]) : 32'h20;
      c7 = (p ^ l) & 32'h7f;
      ref_out[i] = 8'((($countones(c7) & 1) << 7) | c7);
      l = ((l << 1) | ($countones(l & taps) & 1)) & 32'h7f;
    end
  endtask

  // Launch one run and record write timing; cycle 0 is the start-sampling cycle.
  task automatic run(input bit mid_start);
    r_first = -1; r_last = -1; r_done = -1; r_nwr = 0;
    r_addr_ok = 1; r_busy1 = 0; r_busy_end = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 150 && r_done < 0; c++) begin
      @(negedge clk);
      start = mid_start && (c == 10 || c == 60);
      if (c == 1) r_busy1 = int'(busy);
      if (mem_wr_en) begin
        if (r_first < 0) r_first = c;
        r_last = c;
        if (mem_addr != 8'(64 + r_nwr) || c != 6 + 2 * r_nwr) r_addr_ok = 0;
        r_nwr++;
      end
      if (done) begin
        r_done     = c;
        r_busy_end = int'(busy);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    chk({tag, ".first_wr"}, r_first, 6);
    chk({tag, ".last_wr"}, r_last, 132);
    chk({tag, ".done_cyc"}, r_done, 133);
    chk({tag, ".n_wr"}, r_nwr, 64);
    chk({tag, ".wr_seq"}, r_addr_ok, 1);
    chk({tag, ".busy_c1"}, r_busy1, 1);
    chk({tag, ".busy_done"}, r_busy_end, 0);
  endtask

  task automatic check_vs_ref(input string tag);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s.dm%0d", tag, 64 + i), dm[64 + i], ref_out[i]);
  endtask

  localparam string MSG1 = "Mr. Watson, come here. I want to see you.";

  initial begin
    int n_pre;
    int n_post;
    rst   = 1'b1;
    start = 1'b0;
    tb_we = 1'b0;
    tb_waddr = 8'h00;
    tb_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.wr_en", mem_wr_en, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    // start together with rst must be ignored
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio.busy", busy, 0);
    start = 1'b0;
    rst   = 1'b0;

    // Scenario 1 + timing
    build_image(MSG1, 8'd10, 8'h60, 8'h01, 8'h00);
    load_image();
    compute_ref();
    run(1'b0);
    check_timing("s1");
    check_vs_ref("s1");
    chk("s1.dm64", dm[64], 8'h21);
    chk("s1.dm65", dm[65], 8'h22);
    for (int i = 0; i < 64; i++) save_a[i] = dm[64 + i];
    $display("run s1 pre=10 taps=60 init=01 writes=%0d done_cycle=%0d", r_nwr, r_done);

    // Relaunch from DONE
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("relaunch.done", done, 0);
    chk("relaunch.busy", busy, 1);
    chk("relaunch.addr", mem_addr, 61);
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    chk("relaunch.done_end", done, 1);
    check_vs_ref("relaunch");
    $display("run relaunch from done");

    // Scenario 6: start pulses while busy
    build_image(MSG1, 8'd10, 8'h60, 8'h01, 8'hEE);
    load_image();
    run(1'b1);
    check_timing("s6");
    for (int i = 0; i < 64; i++) chk($sformatf("s6.dm%0d", 64 + i), dm[64 + i], save_a[i]);
    $display("run s6 start pulses at 10/60 done_cycle=%0d", r_done);

    // Scenario 2a: pre below range behaves like pre=10
    build_image(MSG1, 8'd3, 8'h60, 8'h01, 8'hEE);
    load_image();
    run(1'b0);
    for (int i = 0; i < 64; i++) chk($sformatf("s2lo.dm%0d", 64 + i), dm[64 + i], save_a[i]);
    $display("run s2 pre=3");

    // Scenario 2b: pre above range behaves like pre=15
    build_image(MSG1, 8'd15, 8'h60, 8'h01, 8'hEE);
    load_image();
    compute_ref();
    run(1'b0);
    check_vs_ref("s2p15");
    for (int i = 0; i < 64; i++) save_b[i] = dm[64 + i];
    build_image(MSG1, 8'hFF, 8'h60, 8'h01, 8'hEE);
    load_image();
    run(1'b0);
    for (int i = 0; i < 64; i++) chk($sformatf("s2hi.dm%0d", 64 + i), dm[64 + i], save_b[i]);
    $display("run s2 pre=15 and pre=FF");

    // Scenario 3: zero init behaves like init=1
    build_image(MSG1, 8'd10, 8'h60, 8'h00, 8'hEE);
    load_image();
    run(1'b0);
    for (int i = 0; i < 64; i++) chk($sformatf("s3.dm%0d", 64 + i), dm[64 + i], save_a[i]);
    $display("run s3 init=00");

    // Scenario 5: reset during the run
    build_image(MSG1, 8'd10, 8'h60, 8'h01, 8'h5A);
    load_image();
    compute_ref();
    n_pre  = 0;
    n_post = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wr_en) begin
        if (c < 50) n_pre++;
        else n_post++;
      end
      if (c == 50) begin
        chk("s5.done", done, 0);
        chk("s5.busy", busy, 0);
        chk("s5.addr", mem_addr, 0);
        rst = 1'b0;
      end
      if (c == 49) rst = 1'b1;
    end
    chk("s5.n_wr_before", n_pre, 22);
    chk("s5.n_wr_after", n_post, 0);
    for (int i = 0; i < 22; i++) chk($sformatf("s5.dm%0d", 64 + i), dm[64 + i], ref_out[i]);
    for (int i = 22; i < 64; i++) chk($sformatf("s5.keep%0d", 64 + i), dm[64 + i], 8'h5A);
    $display("run s5 reset mid-run writes_before=%0d writes_after=%0d", n_pre, n_post);

    // Randomized images
    for (int t = 0; t < 5; t++) begin
      for (int a = 0; a < 128; a++) img[a] = 8'($urandom);
      img[61] = (t == 0) ? 8'($urandom_range(10, 15)) : 8'($urandom);
      if (t == 1) img[63] = 8'h80;
      compute_ref();
      load_image();
      run(1'b0);
      check_timing($sformatf("rnd%0d", t));
      check_vs_ref($sformatf("rnd%0d", t));
      $display("run rnd%0d pre=%0d taps=%02h init=%02h", t, img[61], img[62], img[63]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
